// File: rtl/carry_select_subtractor_seq.sv
// Sequential carry-select subtractor: computes diff = a - b - bin one SLICE-bit slice per clock,
// LSB slice first, with valid/ready handshakes on both the operand and result sides.
module carry_select_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB    = WIDTH - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
    $error("carry_select_subtractor_seq: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] nb_q;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic             accept;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] nb_s;
  logic [SLICE:0]   s0;
  logic [SLICE:0]   s1;
  logic [SLICE:0]   sel;

  // Both candidate slice sums are formed up front; the running carry only steers the mux.
  always_comb begin
    a_s  = a_q[SLICE*int'(idx) +: SLICE];
    nb_s = nb_q[SLICE*int'(idx) +: SLICE];
    s0   = {1'b0, a_s} + {1'b0, nb_s};
    s1   = s0 + (SLICE+1)'(1);
    sel  = carry ? s1 : s0;
  end

  // NOTE: every output of this block gets a default before the case statement, so no latch
  // can be inferred on any path that leaves a signal unassigned.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // NOTE: sequential state is always written with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the operand registers carry no reset; they are only read in RUN, which is always
  // entered through a load, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      nb_q <= ~b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      carry <= ~bin;
      idx   <= '0;
    end else if (state == RUN) begin
      diff[SLICE*int'(idx) +: SLICE] <= sel[SLICE-1:0];
      carry <= sel[SLICE];
      idx   <= idx + IDXW'(1);
      if (idx == LAST_IDX) begin
        bout <= ~sel[SLICE];
        // Operand signs differ exactly when a and ~b share an MSB.
        ovf  <= (a_q[MSB] == nb_q[MSB]) && (sel[SLICE-1] != a_q[MSB]);
      end
    end
  end

endmodule

// File: tb/tb_carry_select_subtractor_seq.sv
// Self-checking bench for carry_select_subtractor_seq: directed cases, back-pressure, reset
// abandonment and randomized operands compared against a plain-arithmetic reference.
module tb_carry_select_subtractor_seq;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  carry_select_subtractor_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, bout, diff} from integer arithmetic on the operands.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                            input logic mbin);
    logic [WIDTH:0] full;
    longint         sd;
    logic           sovf;
    full = {1'b0, ma} - {1'b0, mb} - (WIDTH+1)'(mbin);
    sd   = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
    sovf = (sd < -(longint'(1) <<< (WIDTH-1))) || (sd > ((longint'(1) <<< (WIDTH-1)) - 1));
    return {sovf, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic obin);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", in_ready, 1'b1);
    a        = oa;
    b        = ob;
    bin      = obin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Scramble the inputs; the latched operands must not follow.
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    bin      = 1'($urandom);
  endtask

  task automatic finish_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic obin,
                           input int stall, input bit toggle);
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] held;
    int lat = 0;
    exp = model(oa, ob, obin);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(NSLICE));
    check("diff", diff, exp[WIDTH-1:0]);
    check("bout", bout, exp[WIDTH]);
    check("ovf", ovf, exp[WIDTH+1]);
    held = diff;
    for (int i = 0; i < stall; i++) begin
      if (toggle) begin
        in_valid = 1'($urandom);
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        bin      = 1'($urandom);
      end
      tick();
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_diff", diff, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("handoff_out_valid", out_valid, 1'b0);
    check("handoff_in_ready", in_ready, 1'b1);
    check("handoff_diff_hold", diff, held);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rbin;
    int               n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    tick();
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_diff", diff, '0);
    check("reset_bout", bout, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    start_op(16'h1234, 16'h0034, 1'b0);
    finish_op(16'h1234, 16'h0034, 1'b0, 0, 1'b0);
    check("t1_diff", diff, 16'h1200);

    start_op(16'h1000, 16'h0001, 1'b0);
    finish_op(16'h1000, 16'h0001, 1'b0, 0, 1'b0);
    check("t2a_diff", diff, 16'h0FFF);
    check("t2a_bout", bout, 1'b0);

    start_op(16'h0000, 16'h0001, 1'b0);
    finish_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
    check("t2b_diff", diff, 16'hFFFF);
    check("t2b_bout", bout, 1'b1);
    check("t2b_ovf", ovf, 1'b0);

    start_op(16'h8000, 16'h0001, 1'b0);
    finish_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
    check("t3a_diff", diff, 16'h7FFF);
    check("t3a_ovf", ovf, 1'b1);

    start_op(16'h0005, 16'h0005, 1'b1);
    finish_op(16'h0005, 16'h0005, 1'b1, 0, 1'b0);
    check("t3b_diff", diff, 16'hFFFF);
    check("t3b_bout", bout, 1'b1);
    check("t3b_ovf", ovf, 1'b0);

    // Back-pressure with input churn, then back-to-back operations.
    start_op(16'hBEEF, 16'h1234, 1'b1);
    finish_op(16'hBEEF, 16'h1234, 1'b1, 5, 1'b1);
    start_op(16'h7FFF, 16'hFFFF, 1'b0);
    finish_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
    start_op(16'h0F0F, 16'hF0F0, 1'b1);
    finish_op(16'h0F0F, 16'hF0F0, 1'b1, 0, 1'b0);

    // Reset two cycles into RUN.
    start_op(16'h5678, 16'h1111, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_run_in_ready_low", in_ready, 1'b0);
    tick();
    check("rst_run_out_valid", out_valid, 1'b0);
    check("rst_run_diff", diff, '0);
    check("rst_run_bout", bout, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_run_in_ready", in_ready, 1'b1);
    for (int i = 0; i < NSLICE + 2; i++) begin
      tick();
      check("rst_run_no_stale", out_valid, 1'b0);
    end

    // Reset while the result is waiting in DONE.
    start_op(16'hFFFF, 16'h0001, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("rst_done_reached", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_done_out_valid", out_valid, 1'b0);
    check("rst_done_diff", diff, '0);
    check("rst_done_ovf", ovf, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_done_in_ready", in_ready, 1'b1);
    for (int i = 0; i < NSLICE + 2; i++) begin
      tick();
      check("rst_done_no_stale", out_valid, 1'b0);
    end

    // Randomized operands with random result stalls.
    for (int i = 0; i < 1500; i++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      start_op(ra, rb, rbin);
      finish_op(ra, rb, rbin, $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
